// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// Sits beside the IF-stage PC: predicts direction/target for pc_in in the
// same cycle, is trained by the branch-resolution stage, and keeps
// saturating statistics on resolved branches and mispredicts.
//
// Ports:
//   CLK            clock, all state updates on rising edge
//   nRST           synchronous active-high reset (1 = clear)
//   pc_in          fetch PC to predict (word aligned)
//   pred_taken     predicted direction for pc_in (combinational)
//   pred_target    predicted next PC for pc_in (combinational)
//   upd_valid      a branch resolved this cycle
//   upd_pc         PC of the resolved branch
//   upd_taken      resolved direction
//   upd_target     resolved taken target
//   upd_mispredict resolved branch caused a flush (qualified by upd_valid)
//   flush_all      invalidate every entry
//   stat_clear     zero both statistics counters
//   stat_branches  saturating resolved-branch count
//   stat_mispred   saturating mispredict count
module branch_predictor #(
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned PREDICT_MODE = 1,
    parameter int unsigned STAT_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [31:0]       pc_in,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WN  = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [STAT_W-1:0]   STAT_MAX = {STAT_W{1'b1}};

    // Table storage
    logic [ENTRIES-1:0]  entry_valid;
    logic [TAG_W-1:0]    entry_tag [ENTRIES];
    logic [29:0]         entry_tgt [ENTRIES];
    logic [CTR_BITS-1:0] entry_ctr [ENTRIES];

    // Lookup path (reads registered state only, so no same-cycle bypass)
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = pc_in[IDX_W+1:2];
    assign lk_tag = pc_in[31:IDX_W+2];
    assign lk_hit = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);

    assign pred_taken  = (PREDICT_MODE == 1) && lk_hit && (entry_ctr[lk_idx] >= CTR_WT);
    assign pred_target = pred_taken ? {entry_tgt[lk_idx], 2'b00} : pc_in + 32'd4;

    // Update path
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    logic [CTR_BITS-1:0] up_ctr;
    logic [CTR_BITS-1:0] ctr_inc;
    logic [CTR_BITS-1:0] ctr_dec;

    assign up_idx  = upd_pc[IDX_W+1:2];
    assign up_tag  = upd_pc[31:IDX_W+2];
    assign up_hit  = entry_valid[up_idx] && (entry_tag[up_idx] == up_tag);
    assign up_ctr  = entry_ctr[up_idx];
    assign ctr_inc = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_BITS'(1);
    assign ctr_dec = (up_ctr == '0)      ? up_ctr : up_ctr - CTR_BITS'(1);

    // Word-offset bits carry no information for an aligned PC
    logic unused_lsbs;
    assign unused_lsbs = ^{pc_in[1:0], upd_pc[1:0], upd_target[1:0]};

    // Table update: reset > flush > train; a flush drops the same-cycle update
    always_ff @(posedge CLK) begin
        if (nRST) begin
            entry_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entry_ctr[i] <= CTR_WN;
            end
        end else if (flush_all) begin
            entry_valid <= '0;
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    entry_ctr[up_idx] <= ctr_inc;
                    entry_tgt[up_idx] <= upd_target[31:2];
                end else begin
                    entry_ctr[up_idx] <= ctr_dec;
                end
            end else if (upd_taken) begin
                entry_valid[up_idx] <= 1'b1;
                entry_tag[up_idx]   <= up_tag;
                entry_tgt[up_idx]   <= upd_target[31:2];
                entry_ctr[up_idx]   <= CTR_WT;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge CLK) begin
        if (nRST || stat_clear) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid && (stat_branches != STAT_MAX)) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (upd_valid && upd_mispredict && (stat_mispred != STAT_MAX)) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor. Three instances share one input
// stream: dynamic (default), static not-taken (PREDICT_MODE=0) and a
// narrow-statistics build (STAT_W=4). Stimulus pushes expectations into a
// queue; a monitor pops and compares on the falling edge.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc_in;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush_all;
    logic        stat_clear;

    logic        pt0, pt1, pt2;
    logic [31:0] tg0, tg1, tg2;
    logic [31:0] sb0, sm0, sb1, sm1;
    logic [3:0]  sb2, sm2;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PREDICT_MODE(1), .STAT_W(32)) u_dyn (
        .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .pred_taken(pt0), .pred_target(tg0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .stat_clear(stat_clear),
        .stat_branches(sb0), .stat_mispred(sm0));

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PREDICT_MODE(0), .STAT_W(32)) u_static (
        .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .pred_taken(pt1), .pred_target(tg1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .stat_clear(stat_clear),
        .stat_branches(sb1), .stat_mispred(sm1));

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PREDICT_MODE(1), .STAT_W(4)) u_stat4 (
        .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .pred_taken(pt2), .pred_target(tg2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all), .stat_clear(stat_clear),
        .stat_branches(sb2), .stat_mispred(sm2));

    typedef struct {
        int          dut;
        bit          is_stat;
        bit          taken;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Bench-side count of resolved branches/mispredicts since last clear
    int    nb = 0;
    int    nm = 0;

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic exp_pred(input int dut, input string nm_s, input bit tk, input logic [31:0] tgt);
        exp_t e;
        e.dut = dut; e.is_stat = 1'b0; e.taken = tk; e.a = tgt; e.b = '0;
        exp_q.push_back(e);
        name_q.push_back(nm_s);
    endtask

    task automatic exp_pred_all(input string nm_s, input bit tk, input logic [31:0] tgt);
        exp_pred(0, nm_s, tk, tgt);
        exp_pred(1, nm_s, 1'b0, pc_in + 32'd4);
        exp_pred(2, nm_s, tk, tgt);
    endtask

    task automatic exp_stats(input string nm_s);
        exp_t e;
        e.dut = 0; e.is_stat = 1'b1; e.taken = 1'b0; e.a = 32'(nb); e.b = 32'(nm);
        exp_q.push_back(e);
        name_q.push_back(nm_s);
        e.dut = 2; e.a = 32'(sat15(nb)); e.b = 32'(sat15(nm));
        exp_q.push_back(e);
        name_q.push_back(nm_s);
    endtask

    // Advance one cycle, tracking statistics the way the block should
    task automatic go();
        if (nRST || stat_clear) begin
            nb = 0; nm = 0;
        end else if (upd_valid) begin
            nb++;
            if (upd_mispredict) nm++;
        end
        @(posedge CLK);
        #1;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        flush_all = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input bit tk, input logic [31:0] t, input bit mp);
        upd_valid = 1'b1; upd_pc = p; upd_taken = tk; upd_target = t; upd_mispredict = mp;
    endtask

    // Monitor: compare every expectation queued for this cycle
    exp_t        m_e;
    string       m_n;
    logic        m_tk;
    logic [31:0] m_tg, m_sb, m_sm;

    always @(negedge CLK) begin
        while (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            m_n = name_q.pop_front();
            case (m_e.dut)
                0:       begin m_tk = pt0; m_tg = tg0; m_sb = sb0;        m_sm = sm0;        end
                1:       begin m_tk = pt1; m_tg = tg1; m_sb = sb1;        m_sm = sm1;        end
                default: begin m_tk = pt2; m_tg = tg2; m_sb = 32'(sb2);   m_sm = 32'(sm2);   end
            endcase
            if (m_e.is_stat) begin
                checks++;
                if (m_sb !== m_e.a) begin
                    errors++;
                    $display("FAIL %s dut%0d stat_branches: got %0d want %0d", m_n, m_e.dut, m_sb, m_e.a);
                end
                checks++;
                if (m_sm !== m_e.b) begin
                    errors++;
                    $display("FAIL %s dut%0d stat_mispred: got %0d want %0d", m_n, m_e.dut, m_sm, m_e.b);
                end
            end else begin
                checks++;
                if (m_tk !== m_e.taken) begin
                    errors++;
                    $display("FAIL %s dut%0d pred_taken: got %0b want %0b", m_n, m_e.dut, m_tk, m_e.taken);
                end
                checks++;
                if (m_tg !== m_e.a) begin
                    errors++;
                    $display("FAIL %s dut%0d pred_target: got %08h want %08h", m_n, m_e.dut, m_tg, m_e.a);
                end
            end
        end
    end

    initial begin
        nRST = 1'b1; pc_in = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; flush_all = 1'b0; stat_clear = 1'b0;
        @(posedge CLK); #1;
        go();
        nRST = 1'b0;

        // Reset state
        pc_in = 32'h100;
        exp_pred_all("reset_lookup", 1'b0, 32'h104);
        exp_stats("reset_stats");
        go();

        // Allocate 0x100 -> 0x80; same-cycle lookup still sees the old entry
        pc_in = 32'h100;
        upd(32'h100, 1'b1, 32'h80, 1'b1);
        exp_pred_all("alloc_no_bypass", 1'b0, 32'h104);
        go();

        pc_in = 32'h100;
        exp_pred_all("alloc_hit", 1'b1, 32'h80);
        exp_stats("alloc_stats");
        go();

        pc_in = 32'h140;
        exp_pred_all("tag_mismatch", 1'b0, 32'h144);
        go();

        // Hysteresis: ctr 2 -> 1 (not-taken) -> 2 -> 3 -> 3 -> 2
        pc_in = 32'h100;
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        exp_pred_all("hyst_pre_nt", 1'b1, 32'h80);
        go();

        pc_in = 32'h100;
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        exp_pred_all("hyst_ctr1", 1'b0, 32'h104);
        go();

        pc_in = 32'h100;
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        exp_pred_all("hyst_ctr2", 1'b1, 32'h80);
        go();

        pc_in = 32'h100;
        upd(32'h100, 1'b1, 32'h80, 1'b0);
        exp_pred_all("hyst_ctr3", 1'b1, 32'h80);
        go();

        pc_in = 32'h100;
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        exp_pred_all("hyst_sat", 1'b1, 32'h80);
        go();

        pc_in = 32'h100;
        exp_pred_all("hyst_ctr2_again", 1'b1, 32'h80);
        exp_stats("hyst_stats");
        go();

        // Taken hit overwrites the target
        upd(32'h100, 1'b1, 32'h200, 1'b0);
        go();
        pc_in = 32'h100;
        exp_pred_all("target_overwrite", 1'b1, 32'h200);
        go();

        // Flush beats a same-cycle allocate; statistics still count it
        flush_all = 1'b1;
        upd(32'h100, 1'b1, 32'h80, 1'b1);
        go();
        pc_in = 32'h100;
        exp_pred_all("flush_over_update", 1'b0, 32'h104);
        exp_stats("flush_stats");
        go();

        // Re-allocate after flush starts at weakly taken
        upd(32'h100, 1'b1, 32'h300, 1'b0);
        go();
        pc_in = 32'h100;
        exp_pred_all("realloc", 1'b1, 32'h300);
        // Not-taken miss on the same index must not disturb the entry
        upd(32'h500, 1'b0, 32'h0, 1'b0);
        go();
        pc_in = 32'h100;
        exp_pred_all("nt_miss_keeps", 1'b1, 32'h300);
        go();
        pc_in = 32'h500;
        exp_pred_all("nt_miss_no_alloc", 1'b0, 32'h504);
        // Taken miss replaces the entry at that index
        upd(32'h140, 1'b1, 32'h440, 1'b0);
        go();
        pc_in = 32'h100;
        exp_pred_all("replaced_old", 1'b0, 32'h104);
        go();
        pc_in = 32'h140;
        exp_pred_all("replaced_new", 1'b1, 32'h440);
        go();

        // pc_in+4 wraps at 32 bits
        pc_in = 32'hFFFF_FFFC;
        exp_pred_all("pc_wrap", 1'b0, 32'h0000_0000);
        go();

        // 20 mispredicting updates: narrow counters saturate at 15
        for (int i = 0; i < 20; i++) begin
            upd(32'h800, 1'b0, 32'h0, 1'b1);
            go();
        end
        exp_stats("stat_saturate");
        go();

        // Clear beats a same-cycle increment
        stat_clear = 1'b1;
        upd(32'h800, 1'b0, 32'h0, 1'b1);
        go();
        exp_stats("stat_clear");
        upd(32'h800, 1'b0, 32'h0, 1'b0);
        go();
        exp_stats("stat_after_clear");
        go();

        // Reset mid-stream discards the pending update and empties the table
        nRST = 1'b1;
        upd(32'h900, 1'b1, 32'h1000, 1'b1);
        go();
        nRST = 1'b0;
        pc_in = 32'h900;
        exp_pred_all("reset_drops_update", 1'b0, 32'h904);
        exp_stats("reset_mid_stats");
        go();
        pc_in = 32'h140;
        exp_pred_all("reset_invalidates", 1'b0, 32'h144);
        go();

        @(posedge CLK); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
